// File: rtl/lru_set_tracker_pkg.sv
// lru_pkg: shared types and helpers for the LRU set tracker.
//   state_t         - flush sequencer states
//   is_onehot()     - exactly one bit set
//   oh2idx()        - one-hot to binary index
//   identity_ranks()- packed reset/flush rank vector (way w holds rank w)
// The helpers take vectors sized for the largest supported associativity.
// Callers zero-extend their operands and truncate the results with casts.
package lru_pkg;

   localparam int LRU_MAX_WAYS  = 64;
   localparam int LRU_MAX_WAY_W = 6;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_INIT = 1'b1
   } state_t;

   function automatic logic is_onehot(input logic [LRU_MAX_WAYS-1:0] vec);
      return (vec != '0) && ((vec & (vec - LRU_MAX_WAYS'(1))) == '0);
   endfunction

   function automatic logic [LRU_MAX_WAY_W-1:0] oh2idx(input logic [LRU_MAX_WAYS-1:0] vec);
      logic [LRU_MAX_WAY_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < LRU_MAX_WAYS; i++) begin
         if (vec[i]) idx = idx | LRU_MAX_WAY_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [LRU_MAX_WAYS*LRU_MAX_WAY_W-1:0] identity_ranks(input int ways,
                                                                             input int way_w);
      logic [LRU_MAX_WAYS*LRU_MAX_WAY_W-1:0] r;
      r = '0;
      for (int w = 0; w < ways; w++) begin
         for (int b = 0; b < way_w; b++) begin
            r[w*way_w + b] = w[b];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/lru_set_tracker_rank_update.sv
// lru_rank_update: combinational true-LRU rank update for one set.
//   ranks      in  current ranks, way w at [w*WAY_W +: WAY_W]
//   hit        in  1 = promote hit way, 0 = select and rotate victim
//   way_oh     in  one-hot hit way (ignored on a miss)
//   next_ranks out ranks to write back
//   rsp_way    out hit way or victim way
//   err        out hit vector was zero or multi-hot (ranks left unchanged)
module lru_rank_update
   import lru_pkg::*;
#(
   parameter int WAYS  = 8,
   parameter int WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS*WAY_W-1:0] ranks,
   input  logic                  hit,
   input  logic [WAYS-1:0]       way_oh,
   output logic [WAYS*WAY_W-1:0] next_ranks,
   output logic [WAY_W-1:0]      rsp_way,
   output logic                  err
);

   logic             oh_ok;
   logic [WAY_W-1:0] hit_rank;
   logic [WAY_W-1:0] victim;

   always_comb begin
      oh_ok      = is_onehot(LRU_MAX_WAYS'(way_oh));
      hit_rank   = '0;
      victim     = '0;
      next_ranks = ranks;
      rsp_way    = '0;
      err        = 1'b0;

      for (int w = 0; w < WAYS; w++) begin
         if (way_oh[w]) hit_rank = hit_rank | ranks[w*WAY_W +: WAY_W];
         if (ranks[w*WAY_W +: WAY_W] == '0) victim = victim | WAY_W'(w);
      end

      if (hit) begin
         if (oh_ok) begin
            rsp_way = WAY_W'(oh2idx(LRU_MAX_WAYS'(way_oh)));
            // Only ways more recent than the hit way shift down one place.
            for (int w = 0; w < WAYS; w++) begin
               if (way_oh[w])
                  next_ranks[w*WAY_W +: WAY_W] = WAY_W'(WAYS-1);
               else if (ranks[w*WAY_W +: WAY_W] > hit_rank)
                  next_ranks[w*WAY_W +: WAY_W] = ranks[w*WAY_W +: WAY_W] - WAY_W'(1);
            end
         end else begin
            err = 1'b1;
         end
      end else begin
         rsp_way = victim;
         // WAYS is a power of two, so the WAY_W-bit wrap takes rank 0 to WAYS-1.
         for (int w = 0; w < WAYS; w++) begin
            next_ranks[w*WAY_W +: WAY_W] = ranks[w*WAY_W +: WAY_W] - WAY_W'(1);
         end
      end
   end

endmodule

// File: rtl/lru_set_tracker.sv
// lru_set_tracker: multi-set true-LRU rank tracker with flush sweep.
//   clk, rst (async, active low)
//   i_flush / o_busy           re-initialise all sets; busy while sweeping
//   i_req_* / o_req_ready      one hit or miss request per cycle
//   o_rsp_valid/way/err        registered response, one cycle after accept
//   i_dbg_set / o_dbg_ranks    combinational view of one set's ranks
//
// state   | meaning
// ST_RUN  | accepting requests
// ST_INIT | writing identity ranks to set sweep_idx, one set per cycle
module lru_set_tracker
   import lru_pkg::*;
#(
   parameter int WAYS  = 8,
   parameter int SETS  = 16,
   parameter int WAY_W = $clog2(WAYS),
   parameter int IDX_W = $clog2(SETS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_flush,
   output logic                  o_busy,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [IDX_W-1:0]      i_req_set,
   input  logic                  i_req_hit,
   input  logic [WAYS-1:0]       i_req_way_oh,
   output logic                  o_rsp_valid,
   output logic [WAY_W-1:0]      o_rsp_way,
   output logic                  o_rsp_err,
   input  logic [IDX_W-1:0]      i_dbg_set,
   output logic [WAYS*WAY_W-1:0] o_dbg_ranks
);

   localparam logic [WAYS*WAY_W-1:0] ID_RANKS = (WAYS*WAY_W)'(identity_ranks(WAYS, WAY_W));

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      sweep_idx, sweep_nxt;
   logic [WAYS*WAY_W-1:0] rank_q [SETS];
   logic [WAYS*WAY_W-1:0] upd_ranks;
   logic [WAY_W-1:0]      upd_way;
   logic                  upd_err;
   logic                  accept;

   assign o_req_ready = (state == ST_RUN) && !i_flush;
   assign accept      = i_req_valid && o_req_ready;
   assign o_busy      = (state == ST_INIT);
   assign o_dbg_ranks = rank_q[i_dbg_set];

   lru_rank_update #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_rank_update (
      .ranks      (rank_q[i_req_set]),
      .hit        (i_req_hit),
      .way_oh     (i_req_way_oh),
      .next_ranks (upd_ranks),
      .rsp_way    (upd_way),
      .err        (upd_err)
   );

   always_comb begin
      state_nxt = state;
      sweep_nxt = sweep_idx;
      case (state)
         ST_RUN: begin
            if (i_flush) begin
               state_nxt = ST_INIT;
               sweep_nxt = '0;
            end
         end
         ST_INIT: begin
            if (i_flush) begin
               sweep_nxt = '0;
            end else if (sweep_idx == IDX_W'(SETS-1)) begin
               state_nxt = ST_RUN;
               sweep_nxt = '0;
            end else begin
               sweep_nxt = sweep_idx + IDX_W'(1);
            end
         end
         default: begin
            state_nxt = ST_RUN;
            sweep_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_RUN;
         sweep_idx <= '0;
      end else begin
         state     <= state_nxt;
         sweep_idx <= sweep_nxt;
      end
   end

   // Sweep and request writes are exclusive: ready is low outside ST_RUN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) rank_q[s] <= ID_RANKS;
      end else if (state == ST_INIT) begin
         rank_q[sweep_idx] <= ID_RANKS;
      end else if (accept) begin
         rank_q[i_req_set] <= upd_ranks;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_rsp_valid <= 1'b0;
         o_rsp_way   <= '0;
         o_rsp_err   <= 1'b0;
      end else begin
         o_rsp_valid <= accept;
         if (accept) begin
            o_rsp_way <= upd_way;
            o_rsp_err <= upd_err;
         end
      end
   end

endmodule
